// File: rtl/rv_core_pkg.sv
// rv_core_pkg: shared RV32I core widths, ABI register indices and word/index types
package rv_core_pkg;
  localparam int XLEN_C   = 32;
  localparam int NREGS_C  = 32;
  localparam int REG_AW_C = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 1;
  localparam int REG_SP   = 2;
  localparam int REG_GP   = 3;
  typedef logic [XLEN_C-1:0]   xlen_t;
  typedef logic [REG_AW_C-1:0] reg_idx_t;
endpackage

// File: rtl/reg_wr_decode.sv
// reg_wr_decode: destination index to one-hot write enable, x0 never enabled
//   i_we      write request
//   i_rd_addr destination register index
//   o_wen     one-hot per-register write enable, bit 0 forced low
module reg_wr_decode
  import rv_core_pkg::*;
#(
  parameter int NREGS = NREGS_C
) (
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_rd_addr,
  output logic [NREGS-1:0]         o_wen
);
  always_comb begin
    o_wen = '0;
    o_wen[i_rd_addr] = i_we;
    o_wen[0] = 1'b0;
  end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: RV32I integer register file, two combinational reads, one synchronous write
//   clk, rst_n            clock, asynchronous active-low clear
//   rs1_addr/rs1_data     read port 1 (optional same-cycle forwarding)
//   rs2_addr/rs2_data     read port 2 (optional same-cycle forwarding)
//   we, rd_addr, rd_data  write port, x0 writes discarded
//   dbg_addr/dbg_data     stored-value peek, never forwarded
module reg_file_2r1w
  import rv_core_pkg::*;
#(
  parameter int XLEN   = XLEN_C,
  parameter int NREGS  = NREGS_C,
  parameter int BYPASS = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  input  logic [XLEN-1:0]          rd_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);
  logic [NREGS-1:0] w_wen;
  logic [XLEN-1:0]  w_regs [NREGS];
  logic             w_fwd_ok;
  reg_wr_decode #(.NREGS(NREGS)) u_dec (
    .i_we      (we),
    .i_rd_addr (rd_addr),
    .o_wen     (w_wen)
  );
  // x0 is a flop whose enable the decoder holds low, so it stays at its reset zero
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    logic [XLEN-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_q <= '0;
      else if (w_wen[g]) r_q <= rd_data;
    assign w_regs[g] = r_q;
  end
  // rst_n gates forwarding so reads stay zero while held in reset
  assign w_fwd_ok = (BYPASS != 0) && rst_n && we && (rd_addr != '0);
  assign rs1_data = (w_fwd_ok && rd_addr == rs1_addr) ? rd_data : w_regs[rs1_addr];
  assign rs2_data = (w_fwd_ok && rd_addr == rs2_addr) ? rd_data : w_regs[rs2_addr];
  assign dbg_data = w_regs[dbg_addr];
endmodule
